// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and types for the 8-bit timer APB register block.
//   - Register addresses (decoded from paddr[2:0]; upper address bits must be 0)
//   - TCR bit positions and writable-bit mask
//   - Clock-select encoding for cks
//   - APB phase-tracking FSM state type
package timer_pkg;

  localparam logic [2:0] ADDR_TDR  = 3'd0;
  localparam logic [2:0] ADDR_TCR  = 3'd1;
  localparam logic [2:0] ADDR_TSR  = 3'd2;
  localparam logic [2:0] ADDR_TCNT = 3'd3;
  localparam logic [2:0] ADDR_TIER = 3'd4;

  // TCR layout: [7] LOAD (write-only strobe), [5] DN, [4] EN, [1:0] CKS.
  // Bits 6, 3 and 2 are reserved and read as 0.
  localparam int TCR_CKS_LSB = 0;
  localparam int TCR_EN      = 4;
  localparam int TCR_DN      = 5;
  localparam int TCR_LOAD    = 7;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// timer_apb_fsm: APB3 phase tracker for the timer register block.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE, which moves the FSM to ACCESS. The following cycle is the access
// cycle; if psel and penable are both high there, pready is raised
// combinationally (zero wait states) and the transfer commits at the rising
// edge ending that cycle. ACCESS always returns to IDLE after one cycle, so a
// malformed access cycle is simply dropped. penable without a prior setup is
// ignored.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   psel_i           APB select
//   penable_i        APB access strobe
//   bad_access_i     current address/direction is an error access
//   setup_o          setup phase accepted this cycle (prdata capture strobe)
//   commit_o         transfer commits at the next rising edge
//   pready_o         APB pready
//   pslverr_o        APB pslverr (only ever high alongside pready)
//   state_o          current FSM state (debug)
module timer_apb_fsm
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psel_i,
  input  logic       penable_i,
  input  logic       bad_access_i,
  output logic       setup_o,
  output logic       commit_o,
  output logic       pready_o,
  output logic       pslverr_o,
  output apb_state_e state_o
);

  apb_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (psel_i && !penable_i) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Gating with reset keeps a reset during the access cycle from committing
  // or signalling completion.
  assign setup_o   = (state_q == ST_IDLE) && psel_i && !penable_i && !rst_i;
  assign commit_o  = (state_q == ST_ACCESS) && psel_i && penable_i && !rst_i;
  assign pready_o  = commit_o;
  assign pslverr_o = commit_o && bad_access_i;
  assign state_o   = state_q;

endmodule

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB3 responder and register file for the 8-bit timer.
//
// Registers: 0x00 TDR (RW), 0x01 TCR (RW, LOAD strobe in bit 7),
// 0x02 TSR (write-0-to-clear OVF/UDF flags), 0x03 TCNT (RO, live counter),
// 0x04 TIER (RW bits [1:0]). Addresses 0x05-0xFF read 0, writes ignored.
//
// Optional feature macro: TIMER_APB_PSLVERR_EN. When defined, pslverr is
// raised with pready for unmapped addresses and for writes to TCNT. When
// undefined, pslverr stays 0. Write data for such accesses is always dropped.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   psel, penable, pwrite,       APB3 request
//   paddr, pwdata
//   prdata, pready, pslverr      APB3 response
//   tdr, load, en, dn, cks       control to the counter core
//   cnt_in, ovf_evt, udf_evt     status from the counter core
//   irq                          registered timer interrupt
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tdr,
  output logic              load,
  output logic              en,
  output logic              dn,
  output logic [1:0]        cks,
  input  logic [DATA_W-1:0] cnt_in,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  output logic              irq
);

  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] tdr_q;
  logic              load_q;
  logic              en_q, dn_q;
  logic [1:0]        cks_q;
  logic [1:0]        tsr_q, tsr_d;
  logic [1:0]        tier_q;
  logic              irq_q;

  logic [2:0]        addr_lo;
  logic              upper_zero;
  logic              mapped;
  logic              bad_access;
  logic              setup;
  logic              commit;
  logic              wr_en;
  apb_state_e        fsm_state;

  assign addr_lo    = paddr[2:0];
  assign upper_zero = (paddr[ADDR_W-1:3] == '0);
  assign mapped     = upper_zero && (addr_lo <= ADDR_TIER);

`ifdef TIMER_APB_PSLVERR_EN
  assign bad_access = !mapped || (pwrite && addr_lo == ADDR_TCNT);
`else
  assign bad_access = 1'b0;
`endif

  timer_apb_fsm u_fsm (
    .clk_i        (pclk),
    .rst_i        (preset),
    .psel_i       (psel),
    .penable_i    (penable),
    .bad_access_i (bad_access),
    .setup_o      (setup),
    .commit_o     (commit),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .state_o      (fsm_state)
  );

  // TCNT is read-only, so a write there falls through every register enable.
  assign wr_en = commit && pwrite && mapped;

  // Read data is captured at the setup edge and held through the access
  // cycle; any other cycle loads 0 so prdata is quiet outside transfers.
  always_comb begin
    prdata_d = '0;
    if (setup && mapped) begin
      case (addr_lo)
        ADDR_TDR:  prdata_d = tdr_q;
        ADDR_TCR:  prdata_d = {2'b00, dn_q, en_q, 2'b00, cks_q};
        ADDR_TSR:  prdata_d = {6'b0, tsr_q};
        ADDR_TCNT: prdata_d = cnt_in;
        ADDR_TIER: prdata_d = {6'b0, tier_q};
        default:   prdata_d = '0;
      endcase
    end
  end

  // A written 0 clears a flag; a core event in the same cycle wins.
  always_comb begin
    tsr_d = tsr_q;
    if (wr_en && addr_lo == ADDR_TSR) tsr_d = tsr_q & pwdata[1:0];
    tsr_d = tsr_d | {udf_evt, ovf_evt};
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata_q <= '0;
      tdr_q    <= '0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      dn_q     <= 1'b0;
      cks_q    <= 2'b00;
      tsr_q    <= 2'b00;
      tier_q   <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      prdata_q <= prdata_d;
      tsr_q    <= tsr_d;
      irq_q    <= |(tsr_q & tier_q);
      load_q   <= wr_en && (addr_lo == ADDR_TCR) && pwdata[TCR_LOAD];
      if (wr_en && addr_lo == ADDR_TDR) tdr_q <= pwdata;
      if (wr_en && addr_lo == ADDR_TCR) begin
        en_q  <= pwdata[TCR_EN];
        dn_q  <= pwdata[TCR_DN];
        cks_q <= pwdata[TCR_CKS_LSB +: 2];
      end
      if (wr_en && addr_lo == ADDR_TIER) tier_q <= pwdata[1:0];
    end
  end

  assign prdata = prdata_q;
  assign tdr    = tdr_q;
  assign load   = load_q;
  assign en     = en_q;
  assign dn     = dn_q;
  assign cks    = cks_q;
  assign irq    = irq_q;

endmodule
